axi4_default_slave_responder: RTL

//  Terminating AXI4 responder for transactions the address decoder routes to no slave (unmapped

---
 rtl/axi4_resp_pkg.sv | 25 ++
 rtl/axi4_default_slave_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axi4_resp_pkg.sv
// Shared AXI4 response codes and state encodings for the default slave responder.
package axi4_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Denied accesses answer SLVERR; anything that decoded to no slave answers DECERR.
  function automatic logic [1:0] err_resp(input logic perm_err);
    return perm_err ? RESP_SLVERR : RESP_DECERR;
  endfunction

endpackage

// File: rtl/axi4_default_slave_responder.sv
// Terminating AXI4 slave for decode-error traffic: drains writes, returns zero reads,
// answers SLVERR/DECERR and keeps a saturating error count plus the last offending address.
module axi4_default_slave_responder
  import axi4_resp_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  aw_perm_err,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic                  ar_perm_err,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] last_err_addr,
  output logic                  wlast_mismatch
);

  w_state_t   w_state, w_next;
  r_state_t   r_state, r_next;
  logic [7:0] aw_len;
  logic [8:0] beat_cnt;
  logic [7:0] beats_left;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [1:0] inc;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, b};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign inc   = {1'b0, aw_hs} + {1'b0, ar_hs};
  assign rdata = '0;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave the flops cleanly.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state        <= W_IDLE;
      awready        <= 1'b1;
      wready         <= 1'b0;
      bvalid         <= 1'b0;
      bid            <= '0;
      bresp          <= '0;
      aw_len         <= '0;
      beat_cnt       <= '0;
      wlast_mismatch <= 1'b0;
    end else begin
      w_state        <= w_next;
      awready        <= (w_next == W_IDLE);
      wready         <= (w_next == W_DATA);
      bvalid         <= (w_next == W_RESP);
      wlast_mismatch <= 1'b0;
      if (aw_hs) begin
        bid      <= awid;
        bresp    <= err_resp(aw_perm_err);
        aw_len   <= awlen;
        beat_cnt <= '0;
      end else if (w_hs) begin
        if (beat_cnt != 9'h1FF) beat_cnt <= beat_cnt + 9'd1;
        if (wlast) wlast_mismatch <= (beat_cnt != {1'b0, aw_len});
      end
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // rlast is precomputed one beat ahead so it is a plain register output.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= R_IDLE;
      arready    <= 1'b1;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rid        <= '0;
      rresp      <= '0;
      beats_left <= '0;
    end else begin
      r_state <= r_next;
      arready <= (r_next == R_IDLE);
      rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        rid        <= arid;
        rresp      <= err_resp(ar_perm_err);
        beats_left <= arlen;
        rlast      <= (arlen == 8'd0);
      end else if (r_hs) begin
        if (rlast) begin
          rlast <= 1'b0;
        end else begin
          beats_left <= beats_left - 8'd1;
          rlast      <= (beats_left == 8'd1);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_count     <= '0;
      last_err_addr <= '0;
    end else begin
      err_count <= sat_add(err_count, inc);
      if (aw_hs)      last_err_addr <= awaddr;
      else if (ar_hs) last_err_addr <= araddr;
    end
  end

endmodule
